// File: rtl/alu_result_packer.sv
// rtl/alu_result_packer.sv - buffers ALU result words and streams them out as bytes, low byte first
module alu_result_packer #(
  parameter int IN_WIDTH   = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [IN_WIDTH-1:0]   ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic [BYTE_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  DROP
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_LO,
    SEND_HI
  } state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         rd_next;
  logic [AW:0]           count_q, count_d;
  logic [BYTE_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic                  drop_q, drop_d;
  logic                  fifo_full, handshake, pop, push;
  logic [IN_WIDTH-1:0]   head_word, next_word;

  assign rd_next   = rd_ptr_q + AW'(1);
  assign head_word = mem_q[rd_ptr_q];
  assign next_word = mem_q[rd_next];
  assign fifo_full = (count_q == FULL_CNT);
  assign handshake = tx_valid_q && TX_READY;

  // FIFO bookkeeping: a pop frees the full slot so a same-cycle push still lands
  always_comb begin
    pop      = (state_q == SEND_HI) && handshake;
    push     = ALU_OUT_VALID && (!fifo_full || pop);
    drop_d   = ALU_OUT_VALID && fifo_full && !pop;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + ONE_CNT;
    end else if (pop && !push) begin
      count_d = count_q - ONE_CNT;
    end
  end

  // Byte serializer: the next word follows directly only if it was already queued
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        if (count_q != '0) begin
          tx_data_d  = head_word[BYTE_WIDTH-1:0];
          tx_valid_d = 1'b1;
          state_d    = SEND_LO;
        end
      end
      SEND_LO: begin
        if (handshake) begin
          tx_data_d = head_word[IN_WIDTH-1:BYTE_WIDTH];
          state_d   = SEND_HI;
        end
      end
      SEND_HI: begin
        if (handshake) begin
          if (count_q > ONE_CNT) begin
            tx_data_d = next_word[BYTE_WIDTH-1:0];
            state_d   = SEND_LO;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
    busy_d = !((count_d == '0) && (state_d == IDLE));
  end

  // Control and output registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  // Word storage; contents are only meaningful between the pointers
  always_ff @(posedge CLK) begin
    if (RST && push) begin
      mem_q[wr_ptr_q] <= ALU_OUT;
    end
  end

  assign TX_DATA  = tx_data_q;
  assign TX_VALID = tx_valid_q;
  assign BUSY     = busy_q;
  assign DROP     = drop_q;

endmodule

// File: tb/tb_alu_result_packer.sv
// tb/tb_alu_result_packer.sv - randomized and directed bench for alu_result_packer
module tb_alu_result_packer;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VALID = 1'b0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic        BUSY;
  logic        DROP;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: queue of stored words plus which byte of the head is on offer
  logic [15:0] mq[$];
  int          m_phase = 0;
  logic [7:0]  m_data = '0;
  logic        m_valid = 1'b0, m_busy = 1'b0, m_drop = 1'b0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];

  alu_result_packer #(.IN_WIDTH(16), .BYTE_WIDTH(8), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .BUSY(BUSY), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic rst_n, input logic v, input logic [15:0] d, input logic rdy);
    logic pop;
    if (!rst_n) begin
      mq.delete();
      m_phase = 0;
      m_data  = '0;
      m_drop  = 1'b0;
    end else begin
      pop    = (m_phase == 2) && rdy;
      m_drop = v && (mq.size() == DEPTH) && !pop;
      if (m_phase == 0) begin
        if (mq.size() > 0) begin
          m_phase = 1;
          m_data  = mq[0][7:0];
        end
      end else if (m_phase == 1) begin
        if (rdy) begin
          m_phase = 2;
          m_data  = mq[0][15:8];
        end
      end else if (rdy) begin
        void'(mq.pop_front());
        if (mq.size() > 0) begin
          m_phase = 1;
          m_data  = mq[0][7:0];
        end else begin
          m_phase = 0;
        end
      end
      if (v && !m_drop) mq.push_back(d);
    end
    m_valid = (m_phase != 0);
    m_busy  = (mq.size() > 0) || (m_phase != 0);
  endtask

  task automatic cycle(input logic rst_n, input logic v, input logic [15:0] d, input logic rdy);
    RST = rst_n;
    ALU_OUT_VALID = v;
    ALU_OUT = d;
    TX_READY = rdy;
    if (rst_n && TX_VALID === 1'b1 && rdy) got_q.push_back(TX_DATA);
    @(posedge CLK);
    model_step(rst_n, v, d, rdy);
    @(negedge CLK);
    check_eq("tx_valid", 32'(TX_VALID), 32'(m_valid));
    if (m_valid) check_eq("tx_data", 32'(TX_DATA), 32'(m_data));
    check_eq("busy", 32'(BUSY), 32'(m_busy));
    check_eq("drop", 32'(DROP), 32'(m_drop));
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, rdy);
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
  endtask

  initial begin
    cycle(1'b0, 1'b1, 16'hBEEF, 1'b1);
    cycle(1'b0, 1'b1, 16'hBEEF, 1'b1);
    check_eq("rst_data", 32'(TX_DATA), 32'h0);
    check_eq("rst_valid", 32'(TX_VALID), 32'h0);
    check_eq("rst_busy", 32'(BUSY), 32'h0);
    got_q.delete();

    // single word
    cycle(1'b1, 1'b1, 16'hA55A, 1'b1);
    idle(5, 1'b1);
    exp_q = {8'h5A, 8'hA5};
    check_log("single");

    // backpressure
    cycle(1'b1, 1'b1, 16'h1234, 1'b0);
    idle(5, 1'b0);
    idle(5, 1'b1);
    exp_q = {8'h34, 8'h12};
    check_log("backpressure");

    // overflow
    cycle(1'b1, 1'b1, 16'h1111, 1'b0);
    cycle(1'b1, 1'b1, 16'h2222, 1'b0);
    cycle(1'b1, 1'b1, 16'h3333, 1'b0);
    check_eq("ovf_drop", 32'(DROP), 32'h1);
    idle(8, 1'b1);
    exp_q = {8'h11, 8'h11, 8'h22, 8'h22};
    check_log("overflow");

    // full FIFO, push lands in the SEND_HI handshake cycle
    cycle(1'b1, 1'b1, 16'h5566, 1'b0);
    cycle(1'b1, 1'b1, 16'h7788, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b1, 16'h4444, 1'b1);
    check_eq("full_pushpop_drop", 32'(DROP), 32'h0);
    idle(8, 1'b1);
    exp_q = {8'h66, 8'h55, 8'h88, 8'h77, 8'h44, 8'h44};
    check_log("full_pushpop");

    // streaming
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'(16'hC0D0 + i), 1'b1);
    idle(10, 1'b1);
    got_q.delete();

    // reset during SEND_HI
    cycle(1'b1, 1'b1, 16'h9876, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b1);
    check_eq("midrst_valid", 32'(TX_VALID), 32'h0);
    check_eq("midrst_data", 32'(TX_DATA), 32'h0);
    check_eq("midrst_busy", 32'(BUSY), 32'h0);
    idle(5, 1'b1);
    got_q.delete();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1),
            16'($urandom), ($urandom_range(0, 9) < 6));
    end
    idle(10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_result_packer.md
ALU_RESULT_PACKER -- requirements
Module: alu_result_packer

Interface
REQ-001 Parameter: IN_WIDTH, default 16, result word width; SHALL equal 2*BYTE_WIDTH.
REQ-002 Parameter: BYTE_WIDTH, default 8, width of each transmitted byte.
REQ-003 Parameter: DEPTH, default 2, result FIFO depth in words; SHALL be a power of 2 and at least 2.
REQ-004 Port: CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port: RST  in  1  reset; synchronous, active-low; sampled only on the rising edge of CLK.
REQ-006 Port: ALU_OUT  in  IN_WIDTH  result word from the upstream logic/ALU stage.
REQ-007 Port: ALU_OUT_VALID  in  1  qualifies ALU_OUT for one cycle; no backpressure to the upstream stage.
REQ-008 Port: TX_DATA  out  BYTE_WIDTH  byte offered downstream; registered.
REQ-009 Port: TX_VALID  out  1  TX_DATA valid; registered.
REQ-010 Port: TX_READY  in  1  downstream accepts TX_DATA when TX_VALID and TX_READY are both high.
REQ-011 Port: BUSY  out  1  high while the FIFO is non-empty or a byte is pending; registered.
REQ-012 Port: DROP  out  1  one-cycle pulse: an incoming word was discarded because the FIFO was full; registered.

Function
REQ-013 Each cycle with ALU_OUT_VALID=1, the block SHALL push ALU_OUT into the FIFO, unless the FIFO is full with no pop in the same cycle.
REQ-014 A push into a full FIFO with no same-cycle pop SHALL be discarded, leave FIFO contents unchanged, and assert DROP in the next cycle only.
REQ-015 A push and a pop in the same cycle SHALL both take effect; the count SHALL stay unchanged, including when the FIFO is full.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-017 FSM states SHALL be IDLE, SEND_LO and SEND_HI.
REQ-018 IDLE: TX_VALID=0; if the FIFO is non-empty, load TX_DATA with head[BYTE_WIDTH-1:0], set TX_VALID=1, and go to SEND_LO.
REQ-019 SEND_LO: hold TX_DATA and TX_VALID; on handshake, load head[IN_WIDTH-1:BYTE_WIDTH] and go to SEND_HI.
REQ-020 SEND_HI: hold; on handshake, pop the head word.
REQ-021 On that SEND_HI handshake, if the FIFO will still hold a word, load the next word's low byte and go to SEND_LO with TX_VALID kept high.
REQ-022 On that SEND_HI handshake, if the FIFO will be empty, clear TX_VALID and go to IDLE.
REQ-023 For REQ-021, a word pushed in that same cycle into an otherwise-empty FIFO SHALL NOT count; it is sent via IDLE.
REQ-024 TX_DATA SHALL NOT change while TX_VALID=1 and TX_READY=0.
REQ-025 Bytes SHALL go out low byte first, in push order, without loss or duplication.
REQ-026 Latency: a push at edge N into an empty FIFO in IDLE SHALL give TX_VALID=1 with the low byte at edge N+1 and the high byte at the edge after the first handshake.
REQ-027 Back-to-back words with TX_READY held high SHALL be sent at one byte per cycle with no idle gap.
REQ-028 BUSY SHALL be 0 only when the FIFO is empty and the FSM is in IDLE.

Reset
REQ-029 With RST=0 at a rising edge: FSM=IDLE, pointers=0, count=0, TX_DATA=0, TX_VALID=0, BUSY=0, DROP=0.
REQ-030 Reset SHALL abort any transfer in progress; a partly sent word is lost and no byte is offered after reset release.
REQ-031 ALU_OUT_VALID during a reset cycle SHALL be ignored.

Verification
REQ-032 Single word: push 0xA55A, TX_READY=1 -> TX_DATA 0x5A, then 0xA5 on consecutive cycles; TX_VALID low afterwards; BUSY returns to 0.
REQ-033 Backpressure: push 0x1234, TX_READY=0 for 5 cycles -> TX_DATA holds 0x34 with TX_VALID=1; release -> 0x34, then 0x12.
REQ-034 Overflow: TX_READY=0, push 0x1111, 0x2222, 0x3333 -> DROP pulses once after the third push; output is 0x11, 0x11, 0x22, 0x22; 0x3333 is never sent.
REQ-035 Full with simultaneous push/pop: FIFO full, push 0x4444 in the SEND_HI handshake cycle -> no DROP; 0x4444 is sent last.
REQ-036 Streaming: 4 pushes on consecutive cycles, TX_READY=1, DEPTH=2 -> DROP follows REQ-014, and every accepted word's bytes are sent gap-free.
REQ-037 Mid-transfer reset: RST=0 in SEND_HI for 1 cycle -> all outputs 0 at the next edge; TX_VALID stays 0 until a new push.
